// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    localparam int ITERS_DEFAULT = 32;

    function automatic logic op_is_long(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: iterative MULT/DIV (one bit per cycle), single-cycle MTHI/MTLO,
// and the stall request to the hazard unit while a long op is in flight.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int ITERS = ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_hilo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int CW = $clog2(ITERS);

    md_state_e   state;
    logic [CW-1:0] cnt;
    logic [63:0] acc;
    logic [31:0] rem;
    logic [31:0] opd;
    logic        sign_q, rsign_q, div_q, dz_q;

    logic        is_signed, is_div;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, rem_sh, rem_sub;
    logic        rem_ge;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rmd_fix;

    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        is_div    = (op == MD_DIV) || (op == MD_DIVU);
        a_mag     = (is_signed && a[31]) ? -a : a;
        b_mag     = (is_signed && b[31]) ? -b : b;
        // Multiply: acc[63:32] accumulates, acc[31:0] holds the shifting multiplier.
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
        // Divide: acc[31:0] shifts dividend out and quotient bits in.
        rem_sh    = {rem, acc[31]};
        rem_sub   = rem_sh - {1'b0, opd};
        rem_ge    = ~rem_sub[32];
        prod_fix  = sign_q ? -acc : acc;
        quo_fix   = dz_q ? '1 : (sign_q ? -acc[31:0] : acc[31:0]);
        rmd_fix   = rsign_q ? -rem : rem;
        stall     = (busy & (rd_hilo | start)) | (rd_hilo & start & op_is_long(op));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            opd     <= '0;
            sign_q  <= 1'b0;
            rsign_q <= 1'b0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                acc     <= {32'd0, is_div ? a_mag : b_mag};
                                opd     <= is_div ? b_mag : a_mag;
                                rem     <= '0;
                                sign_q  <= is_signed & (a[31] ^ b[31]);
                                rsign_q <= is_signed & a[31];
                                div_q   <= is_div;
                                dz_q    <= is_div && (b == 32'd0);
                                cnt     <= '0;
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (div_q) begin
                        rem        <= rem_ge ? rem_sub[31:0] : rem_sh[31:0];
                        acc[31:0]  <= {acc[30:0], rem_ge};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITERS - 1)) begin
                        state <= FIX;
                        done  <= 1'b1;
                    end
                end
                FIX: begin
                    if (div_q) begin
                        hi <= rmd_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
